axi4lite_sram_slave: RTL
========================

# axi4lite_sram_slave

AXI4-Lite slave memory that terminates the AXI4-Lite master side of the compute tile's Wishbone-to-AXI4-Lite bridge. It gives the network adapter's Wishbone master a word-addressed, byte-strobed local SRAM behind that bridge. Read and write channels are independent. Out-of-window accesses complete with SLVERR and do not modify memory.

## Interface
Parameters:
- MEM_WORDS, 1024: depth in 32-bit words; power of two, minimum 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to 4*MEM_WORDS.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- s_axi_awaddr  in  32  write address (byte address).
- s_axi_awprot  in  3  ignored.
- s_axi_awvalid  in  1  write-address valid.
- s_axi_awready  out  1  write-address ready.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte enables; bit i enables wdata[8i+7:8i].
- s_axi_wvalid  in  1  write-data valid.
- s_axi_wready  out  1  write-data ready.
- s_axi_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- s_axi_bvalid  out  1  write-response valid.
- s_axi_bready  in  1  write-response ready.
- s_axi_araddr  in  32  read address (byte address).
- s_axi_arprot  in  3  ignored.
- s_axi_arvalid  in  1  read-address valid.
- s_axi_arready  out  1  read-address ready.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response: OKAY or SLVERR.
- s_axi_rvalid  out  1  read-data valid.
- s_axi_rready  in  1  read-data ready.

## Operation
- Address decode: in_range = (addr >= BASE_ADDR) && (addr < BASE_ADDR + 4*MEM_WORDS).
  - Evaluate in 33-bit arithmetic so the comparison never wraps.
  - Word index = (addr - BASE_ADDR) >> 2. addr[1:0] is ignored, so a misaligned address is not an error.
- Write path:
  - Two holding registers, aw_full (address) and w_full (data + strobe). Each is captured on its own handshake, in either order or in the same cycle.
  - s_axi_awready = ~aw_full & ~s_axi_bvalid.
  - s_axi_wready = ~w_full & ~s_axi_bvalid.
  - Commit edge: any edge where aw_full & w_full & ~s_axi_bvalid.
    - If in_range, write each strobed byte; unstrobed bytes keep their value.
    - Set bresp to OKAY if in_range, else SLVERR with memory unchanged.
    - Set bvalid = 1 and clear aw_full and w_full.
  - bvalid and bresp hold stable until the bready handshake; bvalid clears on that edge.
- Read path:
  - s_axi_arready = ~s_axi_rvalid.
  - On the AR handshake edge, register rdata = mem[index] if in_range, else 32'h0. Set rresp to OKAY or SLVERR and set rvalid = 1.
  - rvalid, rdata and rresp hold stable until the rready handshake; rvalid clears on that edge.
- Write/read ordering: when a write commit and an AR handshake to the same word fall on the same edge, the read returns the pre-write data.
- Write/read independence: a pending B response never stalls the read channel, and a pending R response never stalls the write channel.

## Timing
- Reset values, asynchronous:
  - awready = 1, wready = 1, arready = 1.
  - bvalid = 0, rvalid = 0.
  - bresp = 2'b00, rresp = 2'b00, rdata = 32'h0.
  - aw_full = 0, w_full = 0.
  - Memory contents are not reset.
- Write latency: AW and W accepted at edge N -> commit at edge N+1 -> bvalid high after edge N+1. If AW and W are accepted at different edges, N is the later one.
- Write throughput: at most one write every 3 cycles when bready is held high.
- Read latency: AR accepted at edge N -> rvalid high after edge N.
- Read throughput: one read every 2 cycles when rready is held high.
- Ready signals depend only on registered state, with no combinational path from any valid input. Valid outputs never depend on ready inputs.
- Reset asserted mid-transaction:
  - Held AW/W and pending B/R are discarded.
  - A write whose commit edge has not yet occurred does not modify memory.

## Test plan
- Basic write/read:
  - AW 0x10 and W 0xDEADBEEF with strb 0xF in the same cycle -> bvalid two cycles later with bresp 00.
  - Then AR 0x10 -> rvalid next cycle with rdata 0xDEADBEEF, rresp 00.
- Byte strobes and channel ordering:
  - Word 0x20 holds 0x11223344. Write 0xAABBCCDD with strb 4'b0101, W presented 3 cycles before AW.
  - Response: single bresp 00; a read of 0x20 returns 0x11BB33DD.
- Out-of-range accesses (MEM_WORDS=1024, BASE 0):
  - Write to 0x1000 -> bresp 10, memory unchanged.
  - Read 0x1000 -> rresp 10, rdata 0.
  - Read 0xFFFFFFFC -> rresp 10, with no wrap into word 1023.
- Backpressure:
  - Hold bready and rready low for 5 cycles.
  - Response: bvalid/bresp and rvalid/rdata stay stable; awready, wready and arready stay low; a second AW offered is not accepted until the B handshake.
- Same-edge write/read:
  - Word 0x40 holds 0x0. Align the commit of 0x12345678 to 0x40 with an AR handshake to 0x40.
  - Response: this read returns 0x0; the next read returns 0x12345678.
- Reset mid-operation:
  - Accept AW 0x8 only, then assert rst for 1 cycle, then send W alone.
  - Response: no bvalid and no memory change until a new AW is accepted.

Source files
------------

// File: rtl/axi4lite_sram_slave.sv
// AXI4-Lite slave backed by a word-addressed, byte-strobed local SRAM.
// Read and write channels run independently; accesses outside the
// configured window complete with SLVERR and leave memory untouched.
module axi4lite_sram_slave #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);

    localparam int          IDX_W   = $clog2(MEM_WORDS);
    localparam logic [32:0] WIN_LO  = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI  = WIN_LO + 33'(4 * MEM_WORDS);
    localparam logic [1:0]  RESP_OK = 2'b00;
    localparam logic [1:0]  RESP_SE = 2'b10;

    // Window check done in 33 bits so the upper bound can never wrap.
    function automatic logic in_window(input logic [31:0] addr);
        logic [32:0] wide;
        wide = {1'b0, addr};
        return (wide >= WIN_LO) && (wide < WIN_HI);
    endfunction

    // Byte-lane merge: strobed lanes take new data, the rest keep old data.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return result;
    endfunction

    logic [31:0] mem [MEM_WORDS];

    logic              aw_full_r;
    logic [31:0]       aw_addr_r;
    logic              w_full_r;
    logic [31:0]       w_data_r;
    logic [3:0]        w_strb_r;
    logic              bvalid_r;
    logic [1:0]        bresp_r;
    logic              rvalid_r;
    logic [31:0]       rdata_r;
    logic [1:0]        rresp_r;

    logic              commit_s;
    logic              aw_in_range_s;
    logic              ar_in_range_s;
    logic [31:0]       aw_off_s;
    logic [31:0]       ar_off_s;
    logic [IDX_W-1:0]  aw_idx_s;
    logic [IDX_W-1:0]  ar_idx_s;
    logic              unused_s;

    assign s_axi_awready = ~aw_full_r & ~bvalid_r;
    assign s_axi_wready  = ~w_full_r & ~bvalid_r;
    assign s_axi_arready = ~rvalid_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = bresp_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rresp   = rresp_r;

    assign commit_s      = aw_full_r & w_full_r & ~bvalid_r;
    assign aw_in_range_s = in_window(aw_addr_r);
    assign ar_in_range_s = in_window(s_axi_araddr);
    assign aw_off_s      = aw_addr_r - BASE_ADDR;
    assign ar_off_s      = s_axi_araddr - BASE_ADDR;
    assign aw_idx_s      = aw_off_s[IDX_W+1:2];
    assign ar_idx_s      = ar_off_s[IDX_W+1:2];
    assign unused_s      = ^{s_axi_awprot, s_axi_arprot,
                             aw_off_s[31:IDX_W+2], aw_off_s[1:0],
                             ar_off_s[31:IDX_W+2], ar_off_s[1:0]};

    // Write channel: hold AW and W independently, commit once both are held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full_r <= 1'b0;
            aw_addr_r <= 32'h0;
            w_full_r  <= 1'b0;
            w_data_r  <= 32'h0;
            w_strb_r  <= 4'h0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OK;
        end else begin
            if (s_axi_awvalid && s_axi_awready) begin
                aw_full_r <= 1'b1;
                aw_addr_r <= s_axi_awaddr;
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_full_r <= 1'b1;
                w_data_r <= s_axi_wdata;
                w_strb_r <= s_axi_wstrb;
            end
            if (commit_s) begin
                aw_full_r <= 1'b0;
                w_full_r  <= 1'b0;
                bvalid_r  <= 1'b1;
                bresp_r   <= aw_in_range_s ? RESP_OK : RESP_SE;
            end else if (bvalid_r && s_axi_bready) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Memory array update on commit; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (commit_s && aw_in_range_s) begin
            mem[aw_idx_s] <= merge_bytes(mem[aw_idx_s], w_data_r, w_strb_r);
        end
    end

    // Read channel: sample memory on the AR handshake (pre-write data on a collision).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'h0;
            rresp_r  <= RESP_OK;
        end else begin
            if (s_axi_arvalid && s_axi_arready) begin
                rvalid_r <= 1'b1;
                rdata_r  <= ar_in_range_s ? mem[ar_idx_s] : 32'h0;
                rresp_r  <= ar_in_range_s ? RESP_OK : RESP_SE;
            end else if (rvalid_r && s_axi_rready) begin
                rvalid_r <= 1'b0;
            end
        end
    end

endmodule
